branch_resolve_unit: RTL

- Parametrised successor of the ID-stage branch comparator: resolves conditional branches for any DATA_W and adds a DEPTH-entry branch history table (BHT) of 2-bit saturating counters.
- IF stage reads a taken/not-taken prediction by PC; ID stage resolves the branch, updates the BHT and flags mispredicts to hazard/flush logic.
- Sits between IF PC logic and the ID/EX hazard unit; target-address computation stays outside.

---
 rtl/branch_resolve_unit_pkg.sv | 32 +++
 rtl/bht_counter_sat.sv | 34 +++
 rtl/branch_resolve_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch func3 encodings,
// the 2-bit BHT counter type and its saturating step helper.
package branch_resolve_unit_pkg;

  localparam logic [2:0] FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] FUNC3_BNE  = 3'b001;
  localparam logic [2:0] FUNC3_RSV0 = 3'b010;
  localparam logic [2:0] FUNC3_RSV1 = 3'b011;
  localparam logic [2:0] FUNC3_BLT  = 3'b100;
  localparam logic [2:0] FUNC3_BGE  = 3'b101;
  localparam logic [2:0] FUNC3_BLTU = 3'b110;
  localparam logic [2:0] FUNC3_BGEU = 3'b111;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t SNT = 2'b00;
  localparam bht_cnt_t WNT = 2'b01;
  localparam bht_cnt_t WT  = 2'b10;
  localparam bht_cnt_t ST  = 2'b11;

  // One saturating step toward taken (up = 1) or not-taken (up = 0).
  function automatic bht_cnt_t cnt_step(bht_cnt_t c, logic up);
    bht_cnt_t r;
    if (up) begin
      r = (c == ST) ? ST : bht_cnt_t'(c + 2'd1);
    end else begin
      r = (c == SNT) ? SNT : bht_cnt_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bht_counter_sat.sv
// One 2-bit saturating branch-history counter. Resets to weakly not-taken.
module bht_counter_sat
  import branch_resolve_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     inc,
  input  logic     dec,
  output bht_cnt_t cnt
);

  bht_cnt_t cnt_d, cnt_q;

  // Next-state: step only when enabled and exactly one direction is requested.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (inc != dec)) begin
      cnt_d = cnt_step(cnt_q, inc);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution plus a DEPTH-entry BHT of 2-bit counters.
// IF reads a prediction by PC; ID resolves, trains the BHT and flags mispredicts.
// Optional statistics counters are built only when BRANCH_STAT_EN is defined.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned IDX_LSB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic [2:0]        id_func3,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_pred_taken,
  input  logic              id_stall,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [DATA_W-1:0] r2_data,
  output logic              pcsrc,
  output logic              mispredict,
  output logic              illegal_br,
  output logic [31:0]       stat_br_cnt,
  output logic [31:0]       stat_miss_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] if_idx, id_idx;
  logic             active, reserved, cond, upd_en;
  bht_cnt_t         cnt [DEPTH];
  bht_cnt_t         if_cnt;

  // PC bits outside the index field are deliberately ignored (aliasing allowed).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, id_pc};

  assign if_idx = if_pc[IDX_LSB +: IDX_W];
  assign id_idx = id_pc[IDX_LSB +: IDX_W];

  // Branch condition evaluation and outcome flags.
  always_comb begin
    active   = id_valid & id_branch;
    reserved = (id_func3 == FUNC3_RSV0) || (id_func3 == FUNC3_RSV1);
    cond     = 1'b0;
    case (id_func3)
      FUNC3_BEQ:  cond = (r1_data == r2_data);
      FUNC3_BNE:  cond = (r1_data != r2_data);
      FUNC3_BLT:  cond = ($signed(r1_data) <  $signed(r2_data));
      FUNC3_BGE:  cond = ($signed(r1_data) >= $signed(r2_data));
      FUNC3_BLTU: cond = (r1_data <  r2_data);
      FUNC3_BGEU: cond = (r1_data >= r2_data);
      default:    cond = 1'b0;
    endcase
    pcsrc      = active & ~reserved & cond;
    illegal_br = active & reserved;
    mispredict = active & ~reserved & (pcsrc != id_pred_taken);
    upd_en     = active & ~id_stall & ~reserved;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_bht
    bht_counter_sat u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (upd_en && (id_idx == IDX_W'(g))),
      .inc   (pcsrc),
      .dec   (~pcsrc),
      .cnt   (cnt[g])
    );
  end

  // Lookup with bypass so IF sees the value being written this cycle.
  always_comb begin
    if_cnt = cnt[if_idx];
    if (upd_en && (id_idx == if_idx)) begin
      if_cnt = cnt_step(cnt[id_idx], pcsrc);
    end
    if_pred_taken = if_cnt[1];
  end

`ifdef BRANCH_STAT_EN
  logic [31:0] br_q, miss_q;

  // Saturating counts of BHT updates and of updates that were mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (upd_en) begin
      if (br_q != 32'hFFFF_FFFF) begin
        br_q <= br_q + 32'd1;
      end
      if (mispredict && (miss_q != 32'hFFFF_FFFF)) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign stat_br_cnt   = br_q;
  assign stat_miss_cnt = miss_q;
`else
  assign stat_br_cnt   = 32'd0;
  assign stat_miss_cnt = 32'd0;
`endif

endmodule
